// File: rtl/gs_host_link.sv
// Host-side bus master for the General Sound mailbox (#B3 data, #BB command/status).
// Polls the GS flags before each transfer and runs Z80-style I/O cycles paced by CE.
module gs_host_link #(
  parameter int unsigned IO_TICKS   = 3,
  parameter int unsigned POLL_LIMIT = 4095
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_OP,
  input  logic [7:0]  REQ_DATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_TIMEOUT,
  output logic [15:0] A,
  output logic [7:0]  DO,
  input  logic [7:0]  DI,
  output logic        WR_n,
  output logic        RD_n,
  output logic        IORQ_n,
  output logic        M1_n
);

  typedef enum logic [2:0] {
    StIdle, StPollSetup, StPollAct, StPollCheck, StXferSetup, StXferAct, StXferEnd, StResp
  } state_e;

  localparam logic [3:0]  TickLast = 4'(IO_TICKS - 1);
  localparam logic [15:0] PollLast = 16'(POLL_LIMIT - 1);
  localparam logic [15:0] AddrData = 16'h00B3;
  localparam logic [15:0] AddrCmd  = 16'h00BB;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  tick_q, tick_d;
  logic [15:0] poll_q, poll_d;
  logic [7:0]  stat_q, stat_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  do_q, do_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_to_q, rsp_to_d;

  logic        is_write;
  logic        wait_ok;
  logic [15:0] xfer_addr;

  assign is_write  = ~op_q[1];
  assign xfer_addr = op_q[0] ? AddrCmd : AddrData;

  always_comb begin
    unique case (op_q)
      2'b00:   wait_ok = ~stat_q[7];
      2'b01:   wait_ok = ~stat_q[0];
      2'b10:   wait_ok = stat_q[7];
      default: wait_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    tick_d     = tick_q;
    poll_d     = poll_q;
    stat_d     = stat_q;
    addr_d     = addr_q;
    do_d       = do_q;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = rsp_to_q;

    unique case (state_q)
      StIdle: begin
        // Acceptance is CLK-level; the bus side then waits for CE in the setup state.
        if (REQ_VALID) begin
          op_d    = REQ_OP;
          data_d  = REQ_DATA;
          poll_d  = '0;
          addr_d  = AddrCmd;
          state_d = (REQ_OP == 2'b11) ? StXferSetup : StPollSetup;
        end
      end
      StPollSetup: begin
        if (CE) begin
          tick_d  = '0;
          state_d = StPollAct;
        end
      end
      StPollAct: begin
        if (CE) begin
          if (tick_q == TickLast) begin
            stat_d  = DI;
            state_d = StPollCheck;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      StPollCheck: begin
        if (CE) begin
          if (wait_ok) begin
            addr_d  = xfer_addr;
            if (is_write) do_d = data_q;
            state_d = StXferSetup;
          end else if (poll_q == PollLast) begin
            rsp_data_d = 8'h00;
            rsp_to_d   = 1'b1;
            state_d    = StResp;
          end else begin
            poll_d  = poll_q + 16'd1;
            state_d = StPollSetup;
          end
        end
      end
      StXferSetup: begin
        if (CE) begin
          tick_d  = '0;
          state_d = StXferAct;
        end
      end
      StXferAct: begin
        if (CE) begin
          if (tick_q == TickLast) begin
            stat_d  = DI;
            state_d = StXferEnd;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      StXferEnd: begin
        if (CE) begin
          rsp_data_d = is_write ? 8'h00 : stat_q;
          rsp_to_d   = 1'b0;
          state_d    = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      data_q     <= 8'h00;
      tick_q     <= '0;
      poll_q     <= '0;
      stat_q     <= 8'h00;
      addr_q     <= 16'h0000;
      do_q       <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      tick_q     <= tick_d;
      poll_q     <= poll_d;
      stat_q     <= stat_d;
      addr_q     <= addr_d;
      do_q       <= do_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  // Strobes decode straight from the state register, so they rise in the same CLK as leaving ACT.
  assign IORQ_n      = ~((state_q == StPollAct) || (state_q == StXferAct));
  assign RD_n        = ~((state_q == StPollAct) || ((state_q == StXferAct) && !is_write));
  assign WR_n        = ~((state_q == StXferAct) && is_write);
  assign M1_n        = 1'b1;
  assign A           = addr_q;
  assign DO          = do_q;
  assign REQ_READY   = (state_q == StIdle);
  assign RSP_VALID   = (state_q == StResp);
  assign RSP_DATA    = rsp_data_q;
  assign RSP_TIMEOUT = rsp_to_q;

endmodule

// File: doc/gs_host_link.md
Name: gs_host_link

Overview:
- Host-side bus master that drives the General Sound mailbox ports #B3 (data) and #BB (command/status) with Z80-style I/O cycles.
- Sits between a simple request/response client (loader, MCU bridge, test sequencer) and the sound card's host bus: A, DI, DO, WR_n, RD_n, IORQ_n, M1_n.
- Performs the GS flag handshake in hardware: polls #BB status bit7 (data flag) and bit0 (command flag) before each transfer, with a timeout.

Parameters:
- IO_TICKS, 3, CE ticks that IORQ_n and RD_n/WR_n are held low per I/O cycle (1..15).
- POLL_LIMIT, 4095, maximum status polls before a request aborts with timeout (1..65535).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CE  in  1  bus tick enable; all bus-phase timing advances only on CE=1
- REQ_VALID  in  1  client request present
- REQ_READY  out  1  block can accept a request (high only in IDLE)
- REQ_OP  in  2  00 write data, 01 write command, 10 read data, 11 read status
- REQ_DATA  in  8  write payload
- RSP_VALID  out  1  one-CLK pulse: request finished
- RSP_DATA  out  8  read result (status byte for op 11); 8'h00 for writes
- RSP_TIMEOUT  out  1  qualifies RSP_VALID; poll limit reached, no transfer done
- A  out  16  host address to GS
- DO  out  8  host write data to GS DI
- DI  in  8  GS read data (GS DO)
- WR_n  out  1  host write strobe
- RD_n  out  1  host read strobe
- IORQ_n  out  1  host I/O request
- M1_n  out  1  tied high (never an interrupt acknowledge)

Behaviour:
- Reset: IORQ_n=RD_n=WR_n=M1_n=1, A=16'h0000, DO=8'h00, REQ_READY=1, RSP_VALID=0, RSP_DATA=8'h00, RSP_TIMEOUT=0, poll counter=0, state IDLE. Reset mid-cycle releases all strobes in the next CLK and drops the request; no response is issued.
- Accept: a request is accepted when REQ_VALID & REQ_READY. REQ_OP and REQ_DATA are latched, REQ_READY falls, and the poll counter clears.
- Pre-wait condition:
  - op 00: status bit7==0
  - op 01: status bit0==0
  - op 10: status bit7==1
  - op 11: none; goes straight to the transfer.
- States: IDLE -> POLL_SETUP -> POLL_ACT -> POLL_CHECK -> (XFER_SETUP -> XFER_ACT -> XFER_END) -> RESP -> IDLE.
- I/O cycle (shared by poll and transfer):
  - SETUP, one CE tick: A driven (#BB=16'h00BB, #B3=16'h00B3), DO driven for writes, strobes high.
  - ACT, IO_TICKS CE ticks: IORQ_n=0 together with RD_n=0 or WR_n=0. DI is sampled on the final ACT tick.
  - Strobes rise together on leaving ACT. A and DO hold through the following tick.
  - Consecutive cycles always have at least one CE tick with IORQ_n=1 between them, so GS flag edges are seen once per cycle.
- Polls: each poll is a read of #BB. In POLL_CHECK:
  - condition true -> XFER_SETUP.
  - condition false and counter == POLL_LIMIT-1 -> RESP with RSP_TIMEOUT=1.
  - otherwise counter increments -> POLL_SETUP.
- Transfer:
  - op 00 writes REQ_DATA to #B3; op 01 writes to #BB.
  - op 10 reads #B3; op 11 reads #BB.
  - Read data goes to RSP_DATA.
- RESP: RSP_VALID=1 for exactly one CLK regardless of CE. RSP_DATA and RSP_TIMEOUT hold until the next RESP. REQ_READY rises in the next CLK.
- CE=0 freezes state, counters and all bus outputs. A request accepted with CE=0 waits in POLL_SETUP.
- REQ_VALID while busy is ignored, with no queuing. REQ_OP/REQ_DATA changes after acceptance have no effect.
- Minimum latency, op 11: accept, then 1 + IO_TICKS + 1 CE ticks, then RESP.

Test Plan:
- Op 11 with GS status byte 8'h7E, IO_TICKS=3 -> exactly one #BB read with IORQ_n&RD_n low for 3 CE ticks; RSP_VALID with RSP_DATA=8'h7E, RSP_TIMEOUT=0.
- Op 00, data 8'h5A, bit7 initially 0 -> one #BB poll, then a #B3 write of 8'h5A; GS bit7 becomes 1; a second op 00 polls until GS reads its data port.
- Op 01, command 8'h23, GS bit0 held 1 for 5 polls then cleared -> 6 polls, then a #BB write of 8'h23; RSP_TIMEOUT=0.
- Op 10, GS writes 8'hC4 to its output port after 10 polls -> #B3 read returns 8'hC4; GS bit7 clears afterwards.
- Op 10, POLL_LIMIT=8, bit7 never set -> exactly 8 #BB reads, no #B3 access, RSP_VALID with RSP_TIMEOUT=1.
- RESET asserted during XFER_ACT of a write -> strobes high next CLK, no RSP_VALID, REQ_READY=1; CE held low mid-poll -> all outputs frozen.
